// File: rtl/irq_pkg.sv
// irq_pkg: shared FSM states and controller register-map constants for irq_seq.
package irq_pkg;
  typedef enum logic [2:0] {
    IDLE,
    RD_REQ,
    RD,
    ACK,
    DISPATCH,
    IN_SVC,
    EOI_REQ,
    EOI_WR
  } state_t;
  localparam logic [7:0] STAT_ADDR = 8'd0;
  localparam logic [7:0] EOI_ADDR = 8'd8;
  localparam int STAT_PEND_BIT = 7;
  localparam int IRQ_NUM_W = 5;
endpackage

// File: rtl/irq_seq.sv
// irq_seq: reads interrupt status, acknowledges, dispatches the vector and writes EOI on return.
module irq_seq
  import irq_pkg::*;
#(
  parameter logic [15:0] VEC_BASE = 16'h0100,
  parameter int VEC_SHIFT = 2
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        cpu_int,
  output logic        cpu_int_ack,
  input  logic        ie,
  output logic        bus_req,
  input  logic        bus_gnt,
  output logic [7:0]  ic_addr,
  output logic        ic_cs_,
  output logic        ic_oe_,
  output logic        ic_we_,
  input  logic [7:0]  ic_data_in,
  output logic [7:0]  ic_data_out,
  output logic        ic_data_oe,
  output logic        vec_valid,
  output logic [15:0] vec_addr,
  input  logic        vec_taken,
  output logic        in_service,
  input  logic        eoi_req,
  output logic [7:0]  spurious_cnt
);
  state_t state, nxt;
  logic [7:0] stat;
  logic [IRQ_NUM_W-1:0] irq_num;
  logic stat_unused;
  assign stat_unused = ^stat[6:IRQ_NUM_W];
  assign ic_data_out = 8'd0;
  assign vec_addr = VEC_BASE + (16'(irq_num) << VEC_SHIFT);
  always_comb begin
    nxt = state;
    case (state)
      IDLE:     nxt = (cpu_int && ie) ? RD_REQ : IDLE;
      RD_REQ:   nxt = bus_gnt ? RD : RD_REQ;
      RD:       nxt = ACK;
      ACK:      nxt = stat[STAT_PEND_BIT] ? DISPATCH : IDLE;
      DISPATCH: nxt = vec_taken ? IN_SVC : DISPATCH;
      IN_SVC:   nxt = eoi_req ? EOI_REQ : IN_SVC;
      EOI_REQ:  nxt = bus_gnt ? EOI_WR : EOI_REQ;
      EOI_WR:   nxt = IDLE;
      default:  nxt = IDLE;
    endcase
  end
  // Outputs are registered from the next state so each strobe lines up exactly with its state.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= IDLE;
      stat <= 8'd0;
      irq_num <= '0;
      spurious_cnt <= 8'd0;
      bus_req <= 1'b0;
      ic_cs_ <= 1'b1;
      ic_oe_ <= 1'b1;
      ic_we_ <= 1'b1;
      ic_addr <= STAT_ADDR;
      ic_data_oe <= 1'b0;
      cpu_int_ack <= 1'b0;
      vec_valid <= 1'b0;
      in_service <= 1'b0;
    end else begin
      state <= nxt;
      if (state == RD) stat <= ic_data_in;
      if (state == ACK && stat[STAT_PEND_BIT]) irq_num <= stat[IRQ_NUM_W-1:0];
      if (state == ACK && !stat[STAT_PEND_BIT] && spurious_cnt != 8'hFF) spurious_cnt <= spurious_cnt + 8'd1;
      bus_req <= nxt == RD_REQ || nxt == RD || nxt == EOI_REQ || nxt == EOI_WR;
      ic_cs_ <= !(nxt == RD || nxt == EOI_WR);
      ic_oe_ <= nxt != RD;
      ic_we_ <= nxt != EOI_WR;
      ic_addr <= nxt == EOI_WR ? EOI_ADDR : STAT_ADDR;
      ic_data_oe <= nxt == EOI_WR;
      cpu_int_ack <= nxt == ACK;
      vec_valid <= nxt == DISPATCH;
      in_service <= nxt == IN_SVC;
    end
  end
endmodule

// File: tb/tb_irq_seq.sv
// tb_irq_seq: directed checks of irq_seq handshake, spurious counting, stalls, masking, wrap and reset.
module tb_irq_seq;
  logic clk = 1'b0, rst = 1'b1;
  logic cpu_int = 1'b0, ie = 1'b0, bus_gnt = 1'b0, vec_taken = 1'b0, eoi_req = 1'b0;
  logic [7:0] stat_val = 8'h00;
  logic cpu_int_ack, bus_req, ic_cs_, ic_oe_, ic_we_, ic_data_oe, vec_valid, in_service;
  logic [7:0] ic_addr, ic_data_out, spurious_cnt;
  logic [15:0] vec_addr;
  logic w_ack, w_req, w_cs_, w_oe_, w_we_, w_doe, w_vv, w_isv;
  logic [7:0] w_addr, w_dout, w_spur;
  logic [15:0] w_vec;
  int checks = 0, passed = 0;
  int eoi_cnt = 0, ack_cnt = 0, vv_cnt = 0;
  always #5 clk = ~clk;
  irq_seq u_dut (
    .clk(clk), .rst(rst), .cpu_int(cpu_int), .cpu_int_ack(cpu_int_ack), .ie(ie),
    .bus_req(bus_req), .bus_gnt(bus_gnt), .ic_addr(ic_addr), .ic_cs_(ic_cs_),
    .ic_oe_(ic_oe_), .ic_we_(ic_we_), .ic_data_in(stat_val), .ic_data_out(ic_data_out),
    .ic_data_oe(ic_data_oe), .vec_valid(vec_valid), .vec_addr(vec_addr),
    .vec_taken(vec_taken), .in_service(in_service), .eoi_req(eoi_req),
    .spurious_cnt(spurious_cnt)
  );
  irq_seq #(.VEC_BASE(16'hFFF0), .VEC_SHIFT(2)) u_wrap (
    .clk(clk), .rst(rst), .cpu_int(cpu_int), .cpu_int_ack(w_ack), .ie(ie),
    .bus_req(w_req), .bus_gnt(bus_gnt), .ic_addr(w_addr), .ic_cs_(w_cs_),
    .ic_oe_(w_oe_), .ic_we_(w_we_), .ic_data_in(stat_val), .ic_data_out(w_dout),
    .ic_data_oe(w_doe), .vec_valid(w_vv), .vec_addr(w_vec),
    .vec_taken(vec_taken), .in_service(w_isv), .eoi_req(eoi_req),
    .spurious_cnt(w_spur)
  );
  always @(posedge clk) begin
    if (!ic_cs_ && !ic_we_ && ic_data_oe && ic_addr == 8'd8 && ic_data_out == 8'd0) eoi_cnt++;
    if (cpu_int_ack) ack_cnt++;
    if (vec_valid) vv_cnt++;
  end
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic run_spur();
    cpu_int = 1'b1;
    step();
    cpu_int = 1'b0;
    repeat (3) step();
  endtask
  initial begin
    int a0, v0, e0;
    repeat (2) step();
    chk("rst_cs", ic_cs_, 1);
    chk("rst_oe", ic_oe_, 1);
    chk("rst_we", ic_we_, 1);
    chk("rst_req", bus_req, 0);
    chk("rst_vec", vec_addr, 16'h0100);
    chk("rst_spur", spurious_cnt, 0);
    rst = 1'b0;
    ie = 1'b1;
    bus_gnt = 1'b1;
    stat_val = 8'h83;
    step();
    cpu_int = 1'b1;
    step();
    cpu_int = 1'b0;
    chk("rdreq_req", bus_req, 1);
    chk("rdreq_cs", ic_cs_, 1);
    step();
    chk("rd_cs", ic_cs_, 0);
    chk("rd_oe", ic_oe_, 0);
    chk("rd_addr", ic_addr, 0);
    step();
    chk("ack", cpu_int_ack, 1);
    chk("ack_req", bus_req, 0);
    chk("ack_cs", ic_cs_, 1);
    step();
    chk("vv", vec_valid, 1);
    chk("vaddr", vec_addr, 16'h010C);
    chk("ack_once", cpu_int_ack, 0);
    step();
    chk("vv_hold", vec_valid, 1);
    vec_taken = 1'b1;
    step();
    vec_taken = 1'b0;
    chk("insvc", in_service, 1);
    chk("vv_drop", vec_valid, 0);
    a0 = ack_cnt;
    cpu_int = 1'b1;
    repeat (3) step();
    cpu_int = 1'b0;
    chk("nest_insvc", in_service, 1);
    chk("nest_req", bus_req, 0);
    chk("nest_ack", ack_cnt, a0);
    eoi_req = 1'b1;
    step();
    eoi_req = 1'b0;
    chk("eoireq_req", bus_req, 1);
    chk("eoireq_cs", ic_cs_, 1);
    step();
    chk("eoi_we", ic_we_, 0);
    chk("eoi_addr", ic_addr, 8);
    chk("eoi_doe", ic_data_oe, 1);
    chk("eoi_data", ic_data_out, 0);
    step();
    chk("post_eoi_we", ic_we_, 1);
    chk("post_eoi_req", bus_req, 0);
    chk("post_eoi_insvc", in_service, 0);
    chk("eoi_cnt", eoi_cnt, 1);
    stat_val = 8'h00;
    v0 = vv_cnt;
    a0 = ack_cnt;
    run_spur();
    step();
    chk("spur_ack", ack_cnt, a0 + 1);
    chk("spur_cnt1", spurious_cnt, 1);
    chk("spur_novv", vv_cnt, v0);
    chk("spur_noeoi", eoi_cnt, 1);
    for (int i = 1; i < 300; i++) run_spur();
    step();
    chk("spur_sat", spurious_cnt, 255);
    stat_val = 8'h83;
    bus_gnt = 1'b0;
    cpu_int = 1'b1;
    step();
    cpu_int = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_rd_req", bus_req, 1);
      chk("stall_rd_cs", ic_cs_, 1);
    end
    bus_gnt = 1'b1;
    step();
    chk("stall_rd_strobe", ic_cs_, 0);
    repeat (2) step();
    chk("stall_vv", vec_valid, 1);
    vec_taken = 1'b1;
    step();
    vec_taken = 1'b0;
    bus_gnt = 1'b0;
    e0 = eoi_cnt;
    eoi_req = 1'b1;
    step();
    eoi_req = 1'b0;
    for (int i = 0; i < 5; i++) begin
      step();
      chk("stall_eoi_req", bus_req, 1);
      chk("stall_eoi_we", ic_we_, 1);
    end
    bus_gnt = 1'b1;
    step();
    chk("stall_eoi_strobe", ic_we_, 0);
    step();
    chk("stall_eoi_cnt", eoi_cnt, e0 + 1);
    ie = 1'b0;
    a0 = ack_cnt;
    cpu_int = 1'b1;
    repeat (4) step();
    chk("mask_req", bus_req, 0);
    chk("mask_ack", ack_cnt, a0);
    cpu_int = 1'b0;
    ie = 1'b1;
    step();
    stat_val = 8'h9F;
    cpu_int = 1'b1;
    step();
    cpu_int = 1'b0;
    repeat (3) step();
    chk("wrap_vv", w_vv, 1);
    chk("wrap_vec", w_vec, 16'h006C);
    chk("irq31_vec", vec_addr, 16'h017C);
    rst = 1'b1;
    step();
    rst = 1'b0;
    chk("rst2_vv", vec_valid, 0);
    stat_val = 8'h83;
    a0 = ack_cnt;
    cpu_int = 1'b1;
    step();
    cpu_int = 1'b0;
    step();
    chk("mid_rd_cs", ic_cs_, 0);
    #2 rst = 1'b1;
    #1;
    chk("async_cs", ic_cs_, 1);
    chk("async_oe", ic_oe_, 1);
    chk("async_req", bus_req, 0);
    step();
    rst = 1'b0;
    repeat (3) step();
    chk("rst_noack", ack_cnt, a0);
    chk("rst_idle_req", bus_req, 0);
    chk("rst_idle_vv", vec_valid, 0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/irq_seq.md
# irq_seq

CPU-side interrupt sequencer: the initiator end of the interrupt-controller handshake. It sees `cpu_int` from the interrupt controller and becomes the bus master on the controller's 8-bit register port. It reads the status register, asserts `cpu_int_ack`, and hands a computed vector address to the CPU core. When the core signals return-from-interrupt, it writes EOI. It sits between the core's control unit and the controller's `cs_/oe_/we_/addr/data` port, behind the system bus arbiter.

## Interface
Parameters:
- `VEC_BASE`, 16'h0100: base address of the vector table.
- `VEC_SHIFT`, 2: vector address = `VEC_BASE + (irq_num << VEC_SHIFT)`, modulo 2^16.

Ports:
- `clk` in 1: system clock; all state changes on posedge.
- `rst` in 1: reset; asynchronous, active-high.
- `cpu_int` in 1: interrupt request from the controller.
- `cpu_int_ack` out 1: one-cycle acknowledge to the controller.
- `ie` in 1: core global interrupt enable.
- `bus_req` out 1: request for the controller port.
- `bus_gnt` in 1: grant from the arbiter; held while `bus_req` is high.
- `ic_addr` out 8: controller register address.
- `ic_cs_`, `ic_oe_`, `ic_we_` out 1 each: active-low strobes.
- `ic_data_in` in 8: read data from the controller.
- `ic_data_out` out 8: write data.
- `ic_data_oe` out 1: enables the `ic_data_out` tristate driver (external).
- `vec_valid` out 1: vector address available to the core.
- `vec_addr` out 16: handler address.
- `vec_taken` in 1: core has latched `vec_addr`.
- `in_service` out 1: a handler is running.
- `eoi_req` in 1: core executed return-from-interrupt.
- `spurious_cnt` out 8: count of spurious interrupts, saturating.

## Operation
- States: IDLE, RD_REQ, RD, ACK, DISPATCH, IN_SVC, EOI_REQ, EOI_WR.
- IDLE
  - If `cpu_int & ie`, go to RD_REQ.
  - Otherwise stay; `cpu_int` with `ie`=0 is ignored.
- RD_REQ: `bus_req`=1. When `bus_gnt`, go to RD.
- RD
  - Drives `ic_addr`=STAT_ADDR (0), `ic_cs_`=0, `ic_oe_`=0, `bus_req`=1.
  - Captures `ic_data_in` into `stat` at the closing edge, then goes to ACK.
- ACK
  - `cpu_int_ack`=1 for exactly this cycle; `bus_req`=0.
  - If `stat[7]`=1: latch `irq_num`=`stat[4:0]`, go to DISPATCH.
  - Otherwise: spurious. Increment `spurious_cnt` (saturating at 255), go to IDLE, no EOI.
- DISPATCH: `vec_valid`=1, `vec_addr` stable. On `vec_taken`, go to IN_SVC.
- IN_SVC
  - `in_service`=1.
  - `cpu_int` is ignored (no nesting).
  - On `eoi_req`, go to EOI_REQ.
- EOI_REQ: `bus_req`=1. When `bus_gnt`, go to EOI_WR.
- EOI_WR
  - Drives `ic_addr`=EOI_ADDR (8), `ic_cs_`=0, `ic_we_`=0, `ic_data_out`=0, `ic_data_oe`=1, `bus_req`=1.
  - Next state is IDLE.
- `eoi_req` outside IN_SVC and `vec_taken` outside DISPATCH are ignored.
- `ie` is sampled only in IDLE. Clearing it mid-sequence does not abort.
- `vec_addr` arithmetic: `{11'b0, irq_num} << VEC_SHIFT`, zero-extended to 16 bits, added to `VEC_BASE`, carry discarded.

## Timing
- All outputs are registered (Moore) and decoded from the state register plus `stat`/`irq_num`.
- Reset values:
  - State = IDLE.
  - `ic_cs_` = `ic_oe_` = `ic_we_` = 1.
  - `ic_addr` = 0, `ic_data_out` = 0.
  - `ic_data_oe`, `cpu_int_ack`, `bus_req`, `vec_valid`, `in_service` = 0.
  - `spurious_cnt` = 0, `vec_addr` = `VEC_BASE`.
- Latency with `bus_gnt` already high, `cpu_int` first seen at edge N:
  - RD_REQ in cycle N+1.
  - RD strobes in N+2.
  - `cpu_int_ack` in N+3.
  - `vec_valid` in N+4.
- Each extra cycle of `bus_gnt` low adds one cycle in RD_REQ or EOI_REQ.
- The RD strobe is exactly one cycle, so the controller's combinational read data is valid for the whole cycle.
- The EOI write strobe is exactly one cycle; the controller clears its pending flag at the closing edge.
- IDLE may re-accept `cpu_int` on the cycle after EOI_WR.
  - The controller needs one edge to re-arbitrate.
  - A stale `cpu_int` read then yields `stat[7]`=0 and is counted as spurious. This is allowed.
- Reset asserted mid-operation deasserts all strobes and `bus_req` immediately and asynchronously. It does not perform an EOI.

## Structure
- Package `irq_pkg` holds:
  - State enum.
  - Constants STAT_ADDR=8'd0, EOI_ADDR=8'd8, STAT_PEND_BIT=7, IRQ_NUM_W=5.
- No sub-module: single FSM, `stat`/`irq_num` registers and the saturating counter in one module.

## Test plan
- Basic path:
  - Stimulus: `ie`=1, `bus_gnt`=1, controller model reports `stat`=8'h83, `VEC_BASE`=16'h0100, `VEC_SHIFT`=2.
  - Required: `cpu_int_ack` pulse at N+3, `vec_valid` at N+4 with `vec_addr`=16'h010C.
  - Then `eoi_req`: exactly one write to `ic_addr`=8 with data 0.
- Spurious:
  - Stimulus: `cpu_int` pulse, model returns `stat`=8'h00.
  - Required: `cpu_int_ack` pulse, no `vec_valid`, `spurious_cnt`=1, no EOI write; repeat 300 times gives `spurious_cnt`=255.
- Grant stall: `bus_gnt` low for 5 cycles in RD_REQ and EOI_REQ -> strobes start exactly one cycle after `bus_gnt` rises; `bus_req` held throughout.
- Masking/nesting:
  - `ie`=0 with `cpu_int` high -> stays IDLE.
  - `cpu_int` reasserted during IN_SVC -> ignored until EOI completes.
- Wrap: `VEC_BASE`=16'hFFF0, irq 31, `VEC_SHIFT`=2 -> `vec_addr`=16'h006C.
- Reset mid-RD: `rst` pulse while `ic_cs_`=0 -> `ic_cs_`/`ic_oe_` go high the same cycle, state IDLE, no `cpu_int_ack`.
